// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, default timing and line levels.
// Latency: n/a (package only).
// Backpressure: n/a. The receive path imports the same constants, so both ends stay consistent.
package uart_tx_pkg;

    // Frame sequencer states. The receive side decodes the same 3-bit encodings.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // 50 MHz system clock / 9600 baud.
    localparam int DEF_BPS_MAX = 5208;
    // 8N1 framing.
    localparam int DEF_BIT_MAX = 8;

    // A UART line rests at mark (high). The start bit is the opposite level.
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel byte handshake into the UART transmitter (valid/ready).
// Latency: n/a (wires only).
// Backpressure: the source holds tx_valid and tx_data until it sees tx_ready at a clock edge.
//   tx_data  : byte to send, sampled on the accept cycle only
//   tx_valid : source has a byte
//   tx_ready : transmitter idle, can take the byte this cycle
interface uart_tx_if #(
    parameter int BIT_MAX = 8
) ();

    logic [BIT_MAX-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;

    // master = byte source (user/loopback logic), slave = transmitter
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer: while enabled, counts 0..BPS_MAX-1 and pulses tick for one clock at BPS_MAX-1.
// Latency: first tick BPS_MAX cycles after en rises, then every BPS_MAX cycles.
// Backpressure: none. Counter is held at 0 while disabled or cleared.
//   clk  : system clock
//   clr  : synchronous clear, active-high
//   en   : run the counter
//   tick : one-clock pulse marking the last cycle of a bit period
module uart_tx_baud_gen #(
    parameter int BPS_MAX = 5208
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (BPS_MAX > 1) ? $clog2(BPS_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_MAX - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr || !en) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Decoded from the registered count, so the pulse is clean and exactly one cycle wide.
    assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, BIT_MAX data bits LSB first, optional parity, STOP_BITS stop bits.
// Latency: tx drops to the start bit on the accept edge; frame lasts (1+BIT_MAX+P+STOP_BITS)*BPS_MAX cycles.
// Backpressure: tx_ready low for the whole frame; an offered byte waits and is taken in the first idle cycle.
//   clk      : system clock, rising edge
//   rst      : synchronous reset, active-high (abandons any frame in flight)
//   tx_if    : slave side of the tx_data/tx_valid/tx_ready handshake
//   tx       : serial line, idle high, driven straight from a flop
//   tx_busy  : frame in progress (always the inverse of tx_ready)
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data bits
//   (even parity, or odd with PARITY_ODD=1). Without it PARITY_ODD has no effect.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int BPS_MAX    = DEF_BPS_MAX,
    parameter int BIT_MAX    = DEF_BIT_MAX,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave tx_if,
    output logic     tx,
    output logic     tx_busy
);

    // Elaboration-time guard against illegal configurations.
    if (BPS_MAX < 2) begin : g_bad_bps
        $error("uart_tx: BPS_MAX must be >= 2");
    end
    if (BIT_MAX < 5 || BIT_MAX > 8) begin : g_bad_bits
        $error("uart_tx: BIT_MAX must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    // Wide enough to hold BIT_MAX. The same counter also tracks stop bits.
    localparam int BIT_W = $clog2(BIT_MAX + 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(BIT_MAX - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    uart_state_t        state;
    logic [BIT_MAX-1:0] shift_reg;
    logic [BIT_W-1:0]   bit_cnt;
    logic               ready;
    logic               tick;

`ifdef UART_TX_PARITY_EN
    // Computed once at accept time from the whole byte. The shift register is consumed as it
    // shifts, so the parity cannot be taken from it later.
    logic               par_bit;
`endif

    assign tx_if.tx_ready = ready;

    // The bit timer runs only while a frame is on the line.
    uart_tx_baud_gen #(
        .BPS_MAX (BPS_MAX)
    ) u_baud (
        .clk  (clk),
        .clr  (rst),
        .en   (state != IDLE),
        .tick (tick)
    );

    // tx is loaded with the level of the *next* bit on the edge that ends the current one,
    // so the line changes exactly at bit boundaries and never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= LINE_IDLE;
            ready     <= 1'b1;
            tx_busy   <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx      <= LINE_IDLE;
                    ready   <= 1'b1;
                    tx_busy <= 1'b0;
                    if (tx_if.tx_valid && ready) begin
                        shift_reg <= tx_if.tx_data;
`ifdef UART_TX_PARITY_EN
                        par_bit   <= (^tx_if.tx_data) ^ PARITY_ODD[0];
`endif
                        tx        <= ~LINE_IDLE;
                        ready     <= 1'b0;
                        tx_busy   <= 1'b1;
                        bit_cnt   <= '0;
                        state     <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        tx    <= shift_reg[0];
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (tick) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            tx      <= par_bit;
                            state   <= PARITY;
`else
                            tx      <= LINE_IDLE;
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            // shift_reg[1] becomes shift_reg[0] on this same edge.
                            tx      <= shift_reg[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tx    <= LINE_IDLE;
                        state <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (tick) begin
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            ready   <= 1'b1;
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    tx      <= LINE_IDLE;
                    ready   <= 1'b1;
                    tx_busy <= 1'b0;
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with BPS_MAX=4, BIT_MAX=8, STOP_BITS=1.
// Inputs are driven and outputs sampled on the falling clock edge.
// With UART_TX_PARITY_EN a second, odd-parity instance runs in lockstep with the first.
module tb_uart_tx;

    localparam int BPS = 4;
    localparam int NB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NP  = 1;
`else
    localparam int NP  = 0;
`endif
    localparam int NBITS = 1 + NB + NP + 1;
    localparam int FRAME = NBITS * BPS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_if #(.BIT_MAX(NB)) bus ();

    uart_tx #(
        .BPS_MAX    (BPS),
        .BIT_MAX    (NB),
        .STOP_BITS  (1),
        .PARITY_ODD (0)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .tx_if   (bus.slave),
        .tx      (tx),
        .tx_busy (busy)
    );

`ifdef UART_TX_PARITY_EN
    logic tx_o;
    logic busy_o;
    uart_tx_if #(.BIT_MAX(NB)) bus_o ();
    assign bus_o.tx_data  = bus.tx_data;
    assign bus_o.tx_valid = bus.tx_valid;

    uart_tx #(
        .BPS_MAX    (BPS),
        .BIT_MAX    (NB),
        .STOP_BITS  (1),
        .PARITY_ODD (1)
    ) u_dut_odd (
        .clk     (clk),
        .rst     (rst),
        .tx_if   (bus_o.slave),
        .tx      (tx_o),
        .tx_busy (busy_o)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level for bit slot idx of a frame carrying b (slot 0 = start bit).
    function automatic logic frame_bit(input logic [7:0] b, input int idx, input logic odd);
        if (idx == 0) return 1'b0;
        if (idx <= NB) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == NB + 1) return (^b) ^ odd;
`endif
        return 1'b1;
    endfunction

    // Called on a falling edge with tx_valid already up; returns on the falling edge of the
    // first cycle after the accepting rising edge.
    task automatic wait_accept(input string name);
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus.tx_ready === 1'b1) done = 1;
            @(negedge clk);
        end
        if (!done) check({name, "_accept_timeout"}, 0, 1);
    endtask

    // Starting at cycle 1 of a frame: checks every cycle of the line and tx_ready, then checks
    // that the cycle after the frame is idle-high with tx_ready back up.
    task automatic check_frame(input logic [7:0] b, input string name);
        for (int c = 0; c < FRAME; c++) begin
            check($sformatf("%s_tx_c%0d", name, c), tx, frame_bit(b, c / BPS, 1'b0));
            check($sformatf("%s_rdy_c%0d", name, c), bus.tx_ready, 0);
`ifdef UART_TX_PARITY_EN
            check($sformatf("%s_txodd_c%0d", name, c), tx_o, frame_bit(b, c / BPS, 1'b1));
`endif
            @(negedge clk);
        end
        check({name, "_rdy_end"}, bus.tx_ready, 1);
        check({name, "_busy_end"}, busy, 0);
        check({name, "_idle_end"}, tx, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        rst          = 1'b1;

        // 1: reset held three cycles, then quiet idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_tx", tx, 1);
        check("rst_rdy", bus.tx_ready, 1);
        check("rst_busy", busy, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle_tx_%0d", i), tx, 1);
            check($sformatf("idle_rdy_%0d", i), bus.tx_ready, 1);
        end

        // 2: single byte 0x55
        bus.tx_data  = 8'h55;
        bus.tx_valid = 1'b1;
        wait_accept("f55");
        bus.tx_valid = 1'b0;
        check("f55_busy_c0", busy, 1);
        check_frame(8'h55, "f55");

        // 3: back-to-back with tx_valid held: 0xA3 then 0x0F, one idle cycle between
        bus.tx_data  = 8'hA3;
        bus.tx_valid = 1'b1;
        wait_accept("fa3");
        bus.tx_data  = 8'h0F;
        check_frame(8'hA3, "fa3");
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check_frame(8'h0F, "f0f");

        // 4: reset during the third data bit of 0xFF, then a clean 0x01 frame
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        wait_accept("fff");
        bus.tx_valid = 1'b0;
        repeat (13) @(negedge clk);
        check("fff_bit2_tx", tx, 1);
        check("fff_bit2_rdy", bus.tx_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx", tx, 1);
        check("midrst_rdy", bus.tx_ready, 1);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        check("midrst_hold_tx", tx, 1);
        check("midrst_hold_rdy", bus.tx_ready, 1);
        bus.tx_data  = 8'h01;
        bus.tx_valid = 1'b1;
        wait_accept("f01");
        bus.tx_valid = 1'b0;
        check_frame(8'h01, "f01");

        // 5: tx_data changes one cycle after accept; the frame still carries 0x3C
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        wait_accept("f3c");
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b0;
        check_frame(8'h3C, "f3c");

`ifdef UART_TX_PARITY_EN
        // 6: 0x07 has three ones -> even parity bit 1, odd parity bit 0, 44-cycle frame
        bus.tx_data  = 8'h07;
        bus.tx_valid = 1'b1;
        wait_accept("f07");
        bus.tx_valid = 1'b0;
        check_frame(8'h07, "f07");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
